// File: rtl/fetch_pkg.sv
// Shared definitions for the IF stage: default addresses, bubble word and
// the IF/ID pipeline register bundle.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] IMEM_LO_DEF  = 32'h0040_0000;
  localparam logic [31:0] IMEM_HI_DEF  = 32'h0040_4000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Bubble carries the NOP word, zeroed PC fields and valid cleared.
  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: reset value, hold enable, redirect load (word aligned)
// and the +4 incrementer that wraps modulo 2^32.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  // PC update: load beats hold, hold beats increment; low two bits stay zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target & 32'hFFFF_FFFC;
    end else if (!hold) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: drives the fetch address from the PC, captures the returned word
// into the IF/ID register, and applies halt > redirect > stall priority.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (fetch address range fault).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
`ifdef FETCH_BOUNDS_CHECK_EN
  parameter logic [31:0] IMEM_LO  = IMEM_LO_DEF,
  parameter logic [31:0] IMEM_HI  = IMEM_HI_DEF,
`endif
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  input  logic [31:0] Instruction,
  output logic [31:0] ByteAddress,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPc,
  output logic [31:0] IfIdPcPlus4,
  output logic        IfIdValid,
  output logic        Halted,
  output logic        FetchFault
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted_q;
  logic        oob;
  logic        halt_now;
  logic        fault_now;
  logic        stop;
  logic        load;
  logic        hold;
  ifid_t       ifid_p1;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q;
  assign oob        = (pc < IMEM_LO) || (pc > IMEM_HI);
  assign FetchFault = fault_q;
`else
  assign oob        = 1'b0;
  assign FetchFault = 1'b0;
`endif

  // A pending halt masks the range check; either one freezes the stage.
  assign halt_now  = halted_q | Halt;
  assign fault_now = ~halt_now & oob;
  assign stop      = halt_now | fault_now;
  assign load      = RedirectValid & ~stop;
  assign hold      = stop | Stall;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .load     (load),
    .target   (RedirectTarget),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // IF/ID register and sticky status latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_p1  <= ifid_bubble(NOP_WORD);
      halted_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      if (stop) halted_q <= 1'b1;
`ifdef FETCH_BOUNDS_CHECK_EN
      if (fault_now) fault_q <= 1'b1;
`endif
      if (stop || RedirectValid) begin
        ifid_p1 <= ifid_bubble(NOP_WORD);
      end else if (!Stall) begin
        ifid_p1.instr    <= Instruction;
        ifid_p1.pc       <= pc;
        ifid_p1.pc_plus4 <= pc_plus4;
        ifid_p1.valid    <= 1'b1;
      end
    end
  end

  assign ByteAddress = pc;
  assign IfIdInstr   = ifid_p1.instr;
  assign IfIdPc      = ifid_p1.pc;
  assign IfIdPcPlus4 = ifid_p1.pc_plus4;
  assign IfIdValid   = ifid_p1.valid;
  assign Halted      = halted_q;

endmodule
